// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding, scancode constants and mode sizing shared by the PS/2 mode sequencer
package ps2_pkg;
    localparam int MODE_W = 3;
    localparam int MODE_N = 5;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_KEY1 = 8'h16;
    localparam logic [7:0] SC_KEY2 = 8'h1E;
    localparam logic [7:0] SC_KEY3 = 8'h26;
    localparam logic [7:0] SC_KEY4 = 8'h25;
    localparam logic [7:0] SC_KEY5 = 8'h2E;
    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_REQ} state_t;
    function automatic logic [MODE_N-1:0] led_of(input logic [MODE_W-1:0] m);
        return MODE_N'(1) << m;
    endfunction
endpackage

// File: rtl/ps2_key_map.sv
// ps2_key_map: combinational make-code to mode decoder, hit low for unmapped codes
module ps2_key_map
    import ps2_pkg::*;
(
    input  logic [7:0]        code,
    output logic              hit,
    output logic [MODE_W-1:0] mode
);
    // five number-row keys select modes 0..4
    always_comb begin
        hit  = 1'b1;
        mode = '0;
        case (code)
            SC_KEY1: mode = MODE_W'(0);
            SC_KEY2: mode = MODE_W'(1);
            SC_KEY3: mode = MODE_W'(2);
            SC_KEY4: mode = MODE_W'(3);
            SC_KEY5: mode = MODE_W'(4);
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/ps2_mode_sequencer.sv
// ps2_mode_sequencer: turns PS/2 make codes into acknowledged mode changes; PS2_ACK_TIMEOUT_EN adds an ack timeout
module ps2_mode_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_req,
    output logic [MODE_W-1:0] o_req_mode,
    input  logic              i_ack,
    output logic [MODE_W-1:0] o_mode,
    output logic [MODE_N-1:0] o_led,
    output logic              o_err,
    output logic              o_drop
);
    state_t            state;
    logic              hit;
    logic [MODE_W-1:0] key_mode;
`ifdef PS2_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`endif

    ps2_key_map u_key_map (
        .code (i_byte),
        .hit  (hit),
        .mode (key_mode)
    );

    // prefix tracking, request handshake and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_req      <= 1'b0;
            o_req_mode <= '0;
            o_mode     <= '0;
            o_led      <= led_of('0);
            o_err      <= 1'b0;
            o_drop     <= 1'b0;
`ifdef PS2_ACK_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            o_err  <= 1'b0;
            o_drop <= 1'b0;
            o_led  <= led_of(o_mode);
            case (state)
                S_IDLE: if (i_byte_valid) begin
                    if (i_byte == SC_BRK) state <= S_BRK;
                    else if (i_byte == SC_EXT) state <= S_EXT;
                    else if (!hit) o_err <= 1'b1;
                    else if (key_mode != o_mode) begin
                        o_req      <= 1'b1;
                        o_req_mode <= key_mode;
                        state      <= S_REQ;
`ifdef PS2_ACK_TIMEOUT_EN
                        cnt        <= '0;
`endif
                    end
                end
                S_BRK, S_EXT_BRK: if (i_byte_valid) state <= S_IDLE;
                S_EXT: if (i_byte_valid) state <= (i_byte == SC_BRK) ? S_EXT_BRK : S_IDLE;
                S_REQ: begin
                    o_drop <= i_byte_valid;
                    if (i_ack) begin
                        o_mode <= o_req_mode;
                        o_req  <= 1'b0;
                        state  <= S_IDLE;
                    end
`ifdef PS2_ACK_TIMEOUT_EN
                    else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        o_req <= 1'b0;
                        o_err <= 1'b1;
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
